// File: rtl/cpu_bus_pkg.sv
// Shared constants and FSM encoding for the CPU-bus register slave.
// Imported by the register bank and its storage array.
package cpu_bus_pkg;

  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 8;
  localparam int IDX_W    = 3;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/reg_file_8x8.sv
// Eight 8-bit registers: single write port, combinational read mux,
// and a flat view of all registers with register 0 in the low byte.
module reg_file_8x8
  import cpu_bus_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we_i,
  input  logic [IDX_W-1:0]           waddr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic [IDX_W-1:0]           raddr_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        mem_q[i] <= RESET_VAL;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

  always_comb begin
    regs_o = '0;
    for (int i = 0; i < NUM_REGS; i++)
      regs_o[i*DATA_W +: DATA_W] = mem_q[i];
  end

endmodule

// File: rtl/cpu_reg_bank.sv
// CPU-bus register slave: eight registers behind a handshake with
// programmable wait states and out-of-range error reporting.
module cpu_reg_bank
  import cpu_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 8'h00,
  parameter int unsigned       WAIT_CYCLES = 1,
  parameter logic [DATA_W-1:0] RESET_VAL   = 8'h00
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sel,
  input  logic                       wr,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic                       ready,
  output logic                       err,
  output logic [NUM_REGS*DATA_W-1:0] reg_out
);

  localparam bit NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [CNT_W-1:0] CNT_INIT =
    NO_WAIT ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, err_q;
  logic              cap, fire;

  logic [ADDR_W-1:0] t_addr;
  logic [DATA_W-1:0] t_wdata;
  logic              t_wr;
  logic [ADDR_W:0]   off;
  logic              in_rng;
  logic              we;
  logic [DATA_W-1:0] rf_rdata;

  // With no wait states the response fires on the capture edge,
  // so the live inputs stand in for the not-yet-loaded hold regs.
  assign t_addr  = (state_q == IDLE) ? addr  : addr_q;
  assign t_wdata = (state_q == IDLE) ? wdata : wdata_q;
  assign t_wr    = (state_q == IDLE) ? wr    : wr_q;

  assign off    = {1'b0, t_addr} - {1'b0, BASE_ADDR};
  assign in_rng = off < (ADDR_W+1)'(NUM_REGS);
  assign we     = fire & t_wr & in_rng;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel) begin
          cap = 1'b1;
          if (NO_WAIT) begin
            state_d = RESP;
            fire    = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    unique case (1'b1)
      fire &  in_rng &  t_wr: rdata_d = t_wdata;
      fire &  in_rng & ~t_wr: rdata_d = rf_rdata;
      fire & ~in_rng:         rdata_d = '0;
      default:                rdata_d = rdata_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ready_q <= fire;
      err_q   <= fire & ~in_rng;
      if (cap) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        wr_q    <= wr;
      end
    end
  end

  reg_file_8x8 #(
    .RESET_VAL(RESET_VAL)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (we),
    .waddr_i(off[IDX_W-1:0]),
    .wdata_i(t_wdata),
    .raddr_i(off[IDX_W-1:0]),
    .rdata_o(rf_rdata),
    .regs_o (reg_out)
  );

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;

endmodule
